// File: rtl/seg7_scan_sched_if.sv
// Bundle of write-port, display-control and display-output signals for seg7_scan_sched.
// The master side drives digit writes and display controls; the slave side is the scanner.
interface seg7_scan_sched_if;
    // Handshake: a write transfers on a rising edge where wr_valid and wr_ready are both 1;
    // wr_addr/wr_data must be stable while wr_valid=1, and wr_valid seen while wr_ready=0 is ignored.
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       ovr_en;
    logic [3:0] ovr_data;
    logic       lz_blank;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       frame_done;

    modport master (
        output wr_valid, wr_addr, wr_data, ovr_en, ovr_data, lz_blank,
        input  wr_ready, seg, dig_en, frame_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, ovr_en, ovr_data, lz_blank,
        output wr_ready, seg, dig_en, frame_done
    );
endinterface

// File: rtl/seg7_scan_sched.sv
// Four-digit multiplexed 7-segment scanner with dead-time blanking, leading-zero
// suppression, override and a single-entry shadow write committed at frame end.
module seg7_scan_sched #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_sched_if.slave   bus
);

    localparam int              PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0]      digits_q [4];
    logic [3:0]      digits_d [4];
    logic [1:0]      sh_addr_q, sh_addr_d;
    logic [3:0]      sh_data_q, sh_data_d;
    logic            pend_q, pend_d;
    logic            wr_ready_q, wr_ready_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dig_en_q, dig_en_d;
    logic            frame_done_q, frame_done_d;

    phase_e          phase;
    logic            slot_end;
    logic            frame_end;
    logic            accept;
    logic [3:0]      upper_zero;
    logic            lz_hide;
    logic [3:0]      shown_val;

    always_comb begin
        pc_d         = pc_q;
        slot_d       = slot_q;
        digits_d     = digits_q;
        sh_addr_d    = sh_addr_q;
        sh_data_d    = sh_data_q;
        pend_d       = pend_q;
        seg_d        = 7'd0;
        dig_en_d     = 4'd0;

        slot_end  = (pc_q == PC_LAST);
        frame_end = slot_end && (slot_q == 2'd3);
        accept    = bus.wr_valid && wr_ready_q;

        if (slot_end) begin
            pc_d   = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            pc_d   = pc_q + PC_W'(1);
        end

        // Commit and accept never overlap: wr_ready_q is low whenever pend_q is set.
        if (frame_end && pend_q) begin
            digits_d[sh_addr_q] = sh_data_q;
            pend_d              = 1'b0;
        end
        if (accept) begin
            sh_addr_d = bus.wr_addr;
            sh_data_d = bus.wr_data;
            pend_d    = 1'b1;
        end
        wr_ready_d = !pend_d;

        phase = (int'(pc_q) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;

        // upper_zero[k] is set when digits k..3 are all zero.
        upper_zero[3] = (digits_q[3] == 4'd0);
        upper_zero[2] = upper_zero[3] && (digits_q[2] == 4'd0);
        upper_zero[1] = upper_zero[2] && (digits_q[1] == 4'd0);
        upper_zero[0] = upper_zero[1] && (digits_q[0] == 4'd0);
        lz_hide = bus.lz_blank && !bus.ovr_en && (slot_q != 2'd0) && upper_zero[slot_q];

        shown_val = bus.ovr_en ? bus.ovr_data : digits_q[slot_q];

        if (phase == PH_DRIVE && !lz_hide) begin
            dig_en_d = 4'b0001 << slot_q;
            seg_d    = hex_decode(shown_val);
        end
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            slot_q       <= 2'd0;
            digits_q     <= '{default: 4'd0};
            sh_addr_q    <= 2'd0;
            sh_data_q    <= 4'd0;
            pend_q       <= 1'b0;
            wr_ready_q   <= 1'b1;
            seg_q        <= 7'd0;
            dig_en_q     <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            slot_q       <= slot_d;
            digits_q     <= digits_d;
            sh_addr_q    <= sh_addr_d;
            sh_data_q    <= sh_data_d;
            pend_q       <= pend_d;
            wr_ready_q   <= wr_ready_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.seg        = seg_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Bench for seg7_scan_sched: directed scenarios followed by random traffic, every cycle
// compared against a cycle-count based reference of the scan schedule.
module tb_seg7_scan_sched;
    localparam int P = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_sched_if bus ();

    seg7_scan_sched #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [16];
    int         t;
    logic [3:0] md [4];
    bit         m_pend;
    logic [1:0] m_addr;
    logic [3:0] m_data;
    bit         m_ready;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    // One clock: predict outputs from the frame position t, step the model, then compare.
    task automatic step();
        logic [6:0] e_seg;
        logic [3:0] e_dig;
        logic       e_fd;
        logic [3:0] v;
        int         pc;
        int         slot;
        bit         hide;
        bit         acc;
        e_seg = 7'd0;
        e_dig = 4'd0;
        e_fd  = 1'b0;
        if (!rst) begin
            pc   = t % P;
            slot = (t / P) % 4;
            v    = bus.ovr_en ? bus.ovr_data : md[slot];
            hide = bus.lz_blank && !bus.ovr_en && (slot != 0);
            for (int k = slot; k < 4; k++)
                if (md[k] != 4'd0) hide = 1'b0;
            if (pc >= B && !hide) begin
                e_dig = 4'(1 << slot);
                e_seg = hex_tab[v];
            end
            e_fd = (pc == P - 1) && (slot == 3);
        end
        acc = !rst && bus.wr_valid && m_ready;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) md[k] = 4'd0;
            m_pend = 1'b0;
            t      = 0;
        end else begin
            if (e_fd && m_pend) begin
                md[m_addr] = m_data;
                m_pend     = 1'b0;
            end
            if (acc) begin
                m_addr = bus.wr_addr;
                m_data = bus.wr_data;
                m_pend = 1'b1;
            end
            t++;
        end
        m_ready = !m_pend;
        #1;
        check("seg", bus.seg, e_seg);
        check("dig_en", {3'd0, bus.dig_en}, {3'd0, e_dig});
        check("frame_done", {6'd0, bus.frame_done}, {6'd0, e_fd});
        check("wr_ready", {6'd0, bus.wr_ready}, {6'd0, m_ready});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d);
        bit done;
        done         = 1'b0;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            done = m_ready;
            step();
        end
        bus.wr_valid = 1'b0;
        check("write_accept_in_time", {6'd0, done}, 7'd1);
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 64 && ((t / P) % 4 != s || t % P != 0); i++) step();
    endtask

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        t = 0;
        for (int k = 0; k < 4; k++) md[k] = 4'd0;
        m_pend = 1'b0; m_addr = 2'd0; m_data = 4'd0; m_ready = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 4'd0;
        bus.ovr_en = 1'b0; bus.ovr_data = 4'd0; bus.lz_blank = 1'b0;

        // Reset values, then two full frames of idle scanning.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(64);

        // Write digit 2 = A during slot 1; visible only from the next frame.
        wait_slot(1);
        run(3);
        do_write(2'd2, 4'hA);
        run(72);

        // Leading-zero blanking with 0,0,0,5 and then 0,1,0,0.
        do_write(2'd2, 4'h0);
        do_write(2'd0, 4'h5);
        run(32);
        bus.lz_blank = 1'b1;
        run(40);
        do_write(2'd0, 4'h0);
        do_write(2'd2, 4'h1);
        run(40);

        // Override shows on every slot immediately and leaves stored digits untouched.
        bus.ovr_data = 4'h8;
        bus.ovr_en   = 1'b1;
        run(20);
        do_write(2'd3, 4'h9);
        run(20);
        bus.ovr_en = 1'b0;
        run(40);
        bus.lz_blank = 1'b0;

        // Accept a write, then reset before the frame ends: write is discarded.
        wait_slot(0);
        do_write(2'd1, 4'h7);
        run(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(70);

        // Random traffic with occasional override, blanking and reset changes.
        for (int i = 0; i < 500; i++) begin
            bus.wr_valid = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 2'($urandom_range(0, 3));
            bus.wr_data  = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
            if (i % 37 == 0) begin
                bus.ovr_en   = ($urandom_range(0, 3) == 0);
                bus.ovr_data = 4'($urandom_range(0, 15));
                bus.lz_blank = ($urandom_range(0, 1) == 1);
            end
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seg7_scan_sched.md
SEG7_SCAN_SCHED -- requirements
Module: seg7_scan_sched

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1000: clock cycles per digit slot; legal range is PRESCALE >= BLANK_CYCLES+1.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4: dead-time cycles at the start of each slot; legal range is >= 0.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: digit write request.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write.
REQ-007 The block SHALL have port wr_addr, input, 2 bits: target digit 0..3 (0 = least significant).
REQ-008 The block SHALL have port wr_data, input, 4 bits: hex digit value.
REQ-009 The block SHALL have port ovr_en, input, 1 bit: override; every slot displays ovr_data.
REQ-010 The block SHALL have port ovr_data, input, 4 bits: override value.
REQ-011 The block SHALL have port lz_blank, input, 1 bit: enable leading-zero blanking.
REQ-012 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-high.
REQ-013 The block SHALL have port dig_en, output, 4 bits: digit enable, one-hot or zero, active-high.
REQ-014 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse at each frame end.

Function
REQ-015 The block SHALL hold four 4-bit digit registers D0..D3, a shadow entry (addr, data, pending flag), a prescale counter pc (0..PRESCALE-1) and a slot counter (0..3).
REQ-016 pc SHALL increment every cycle; at pc==PRESCALE-1, pc SHALL wrap to 0 and slot SHALL advance modulo 4 (3->0).
REQ-017 Slot phase SHALL be BLANK while pc < BLANK_CYCLES and DRIVE otherwise.
REQ-018 In BLANK, the block SHALL output dig_en=0000 and seg=0000000.
REQ-019 In DRIVE, the block SHALL output dig_en=1<<slot and seg=decode(V), where V=ovr_data if ovr_en=1, else D[slot].
REQ-020 seg, dig_en and frame_done SHALL be registered, each reflecting pc/slot/inputs of the previous cycle (1-cycle latency).
REQ-021 decode SHALL be the standard hex map: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-022 Write handshake: a write SHALL be accepted on an edge where wr_valid=1 and wr_ready=1; on acceptance, addr/data SHALL be captured into the shadow entry and pending set.
REQ-023 wr_ready SHALL be the registered value of !pending; wr_valid while wr_ready=0 SHALL be ignored, with no state change.
REQ-024 Commit: on the edge where pc==PRESCALE-1 and slot==3, a pending shadow entry SHALL be written to D[addr] and pending cleared; the new value first appears in slot 0 of the next frame.
REQ-025 frame_done SHALL be 1 for exactly the cycle after that commit edge, every frame, whether or not a commit occurred.
REQ-026 Acceptance and commit cannot coincide, because wr_ready=0 whenever pending=1; wr_ready SHALL return to 1 in the cycle frame_done=1.
REQ-027 Leading-zero blanking: with lz_blank=1 and ovr_en=0, digit k (k=3,2,1) SHALL be treated as BLANK for its whole slot when D[k..3] are all 0.
REQ-028 D0 SHALL never be blanked by leading-zero blanking.
REQ-029 ovr_en SHALL neither modify D0..D3 nor block writes or commits.
REQ-030 ovr_en and lz_blank changes SHALL take effect on the next cycle's output, without waiting for a slot boundary.

Reset
REQ-031 While rst=1 at an edge, the block SHALL clear D0..D3, pc, slot and pending, and drive seg=0, dig_en=0 and frame_done=0.
REQ-032 After the first edge following rst falling, wr_ready SHALL be 1.
REQ-033 Reset asserted mid-frame or with a pending write SHALL discard the pending write and restart at slot 0, pc 0.

Verification (PRESCALE=8, BLANK_CYCLES=2)
REQ-034 Reset release -> each slot shows 2 cycles dig_en=0000, then 6 cycles dig_en one-hot (0001, 0010, 0100, 1000) with seg=0x3F; frame_done pulses every 32 cycles.
REQ-035 Write addr=2, data=A during slot 1 -> wr_ready=0 next cycle; slot 2 still shows 0x3F in this frame; wr_ready=1 with frame_done; next frame slot 2 shows 0x77.
REQ-036 lz_blank=1, D3..D0=0,0,0,5 -> slots 1-3 dig_en=0000, slot 0 shows 0x6D; with D3..D0=0,1,0,0 -> slot 3 is blank, slots 2, 1, 0 show 0x06, 0x3F, 0x3F.
REQ-037 ovr_en=1, ovr_data=8 -> all slots show 0x7F next cycle; after ovr_en=0, stored digits reappear unchanged.
REQ-038 Accept a write, then assert rst for 1 cycle before the frame ends -> after release, wr_ready=1, D0..D3 all 0, no commit occurs, and the first frame_done occurs 32 cycles later.
